// File: rtl/jtag_gpio_regs.sv
// JTAG data-register back end: BYPASS / GPIO_CONFIG / GPIO_DATA / IDCODE chains driving GPIO registers.
// Define JTAG_GPIO_SYNC_EN to pass gpio_in through a 2-flop tck synchronizer before DATA capture.
module jtag_gpio_regs #(
    parameter int          IR_BITS  = 4,
    parameter int          NR_GPIOS = 8,
    parameter logic [31:0] IDCODE   = 32'h1234_5679
) (
    input  logic                tck,
    input  logic                reset,
    input  logic                tdi,
    output logic                tdo,
    input  logic [IR_BITS-1:0]  ir,
    input  logic                capture_dr,
    input  logic                shift_dr,
    input  logic                update_dr,
    input  logic [NR_GPIOS-1:0] gpio_in,
    output logic [NR_GPIOS-1:0] gpio_out,
    output logic [NR_GPIOS-1:0] gpio_oe
);

    typedef enum logic [1:0] {
        CH_BYPASS = 2'd0,
        CH_CONFIG = 2'd1,
        CH_DATA   = 2'd2,
        CH_IDCODE = 2'd3
    } chain_e;

    chain_e              sel_chain;
    logic [NR_GPIOS-1:0] pins_sampled;

    logic                bypass_sr_q, bypass_sr_d;
    logic [NR_GPIOS-1:0] cfg_sr_q,    cfg_sr_d;
    logic [NR_GPIOS-1:0] data_sr_q,   data_sr_d;
    logic [31:0]         id_sr_q,     id_sr_d;
    logic [NR_GPIOS-1:0] gpio_oe_q,   gpio_oe_d;
    logic [NR_GPIOS-1:0] gpio_out_q,  gpio_out_d;

    // Unassigned instruction codes fall back to BYPASS.
    always_comb begin
        if (ir == IR_BITS'(1))
            sel_chain = CH_CONFIG;
        else if (ir == IR_BITS'(2))
            sel_chain = CH_DATA;
        else if (ir == IR_BITS'(3))
            sel_chain = CH_IDCODE;
        else
            sel_chain = CH_BYPASS;
    end

`ifdef JTAG_GPIO_SYNC_EN
    logic [NR_GPIOS-1:0] sync1_q, sync2_q;

    always_ff @(posedge tck) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
        end
    end

    assign pins_sampled = sync2_q;
`else
    assign pins_sampled = gpio_in;
`endif

    // Strobe priority is capture > shift > update; only the selected chain moves.
    always_comb begin
        bypass_sr_d = bypass_sr_q;
        cfg_sr_d    = cfg_sr_q;
        data_sr_d   = data_sr_q;
        id_sr_d     = id_sr_q;
        gpio_oe_d   = gpio_oe_q;
        gpio_out_d  = gpio_out_q;
        unique case (sel_chain)
            CH_BYPASS: begin
                if (capture_dr)
                    bypass_sr_d = 1'b0;
                else if (shift_dr)
                    bypass_sr_d = tdi;
            end
            CH_CONFIG: begin
                if (capture_dr)
                    cfg_sr_d = gpio_oe_q;
                else if (shift_dr)
                    cfg_sr_d = NR_GPIOS'({tdi, cfg_sr_q} >> 1);
                else if (update_dr)
                    gpio_oe_d = cfg_sr_q;
            end
            CH_DATA: begin
                if (capture_dr)
                    data_sr_d = pins_sampled;
                else if (shift_dr)
                    data_sr_d = NR_GPIOS'({tdi, data_sr_q} >> 1);
                else if (update_dr)
                    gpio_out_d = data_sr_q;
            end
            CH_IDCODE: begin
                if (capture_dr)
                    id_sr_d = IDCODE;
                else if (shift_dr)
                    id_sr_d = {tdi, id_sr_q[31:1]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge tck) begin
        if (reset) begin
            bypass_sr_q <= 1'b0;
            cfg_sr_q    <= '0;
            data_sr_q   <= '0;
            id_sr_q     <= '0;
            gpio_oe_q   <= '0;
            gpio_out_q  <= '0;
        end else begin
            bypass_sr_q <= bypass_sr_d;
            cfg_sr_q    <= cfg_sr_d;
            data_sr_q   <= data_sr_d;
            id_sr_q     <= id_sr_d;
            gpio_oe_q   <= gpio_oe_d;
            gpio_out_q  <= gpio_out_d;
        end
    end

    // tdo is quiet outside strobes, so the bit after capture is sr[0] of the fresh snapshot.
    always_comb begin
        tdo = 1'b0;
        if (!reset && (capture_dr || shift_dr || update_dr)) begin
            unique case (sel_chain)
                CH_BYPASS: tdo = bypass_sr_q;
                CH_CONFIG: tdo = cfg_sr_q[0];
                CH_DATA:   tdo = data_sr_q[0];
                CH_IDCODE: tdo = id_sr_q[0];
                default:   tdo = 1'b0;
            endcase
        end
    end

    assign gpio_oe  = gpio_oe_q;
    assign gpio_out = gpio_out_q;

endmodule
